// File: rtl/afe_l2_chan_ctrl_if.sv
// Sample stream in and L2 write port out of one AFE channel, named from the controller's side.
interface afe_l2_chan_ctrl_if #(
  parameter int unsigned AW = 12
);
  logic [31:0]   data_i;
  logic          data_valid_i;
  logic          data_ready_o;
  logic          l2_req_o;
  logic          l2_gnt_i;
  logic [AW-1:0] l2_addr_o;
  logic [31:0]   l2_wdata_o;
  logic [3:0]    l2_be_o;

  modport master (
    input  data_i, data_valid_i, l2_gnt_i,
    output data_ready_o, l2_req_o, l2_addr_o, l2_wdata_o, l2_be_o
  );

  modport slave (
    output data_i, data_valid_i, l2_gnt_i,
    input  data_ready_o, l2_req_o, l2_addr_o, l2_wdata_o, l2_be_o
  );
endinterface

// File: rtl/afe_l2_chan_ctrl.sv
// AFE channel-to-L2 writer: one sample per RUN->REQ round trip (max one sample every two cycles).
// Sample stalls (ready low) while a write waits for grant; req/addr/data/be hold until granted.
module afe_l2_chan_ctrl #(
  parameter int unsigned L2_AWIDTH_NOAL = 12,
  parameter int unsigned L2_TRANS_SIZE  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
  input  logic [L2_TRANS_SIZE-1:0]  cfg_size_i,
  input  logic [1:0]                cfg_datasize_i,
  input  logic                      cfg_continuous_i,
  input  logic                      cfg_en_i,
  input  logic                      cfg_clr_i,
  output logic                      cfg_en_o,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_curr_addr_o,
  output logic [L2_TRANS_SIZE-1:0]  cfg_bytes_left_o,
  afe_l2_chan_ctrl_if.master        bus,
  output logic                      evt_done_o
);

  typedef enum logic [1:0] {IDLE, RUN, REQ} state_e;

  state_e                    state_q, state_d;
  logic [L2_AWIDTH_NOAL-1:0] curr_addr_q, curr_addr_d;
  logic [L2_TRANS_SIZE-1:0]  bytes_left_q, bytes_left_d;
  logic [1:0]                datasize_q, datasize_d;
  logic                      continuous_q, continuous_d;
  logic [31:0]               wdata_q, wdata_d;
  logic                      done_q, done_d;

  logic [2:0]                step;
  logic [31:0]               wdata_rep;
  logic [3:0]                be;

  always_comb begin
    case (datasize_q)
      2'b00:   begin step = 3'd1; wdata_rep = {4{bus.data_i[7:0]}};  end
      2'b01:   begin step = 3'd2; wdata_rep = {2{bus.data_i[15:0]}}; end
      default: begin step = 3'd4; wdata_rep = bus.data_i;            end
    endcase
  end

  always_comb begin
    be = 4'b0000;
    if (state_q == REQ) begin
      case (datasize_q)
        2'b00:   be = 4'b0001 << curr_addr_q[1:0];
        2'b01:   be = 4'b0011 << {curr_addr_q[1], 1'b0};
        default: be = 4'b1111;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    curr_addr_d  = curr_addr_q;
    bytes_left_d = bytes_left_q;
    datasize_d   = datasize_q;
    continuous_d = continuous_q;
    wdata_d      = wdata_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_en_i && (cfg_size_i != '0)) begin
          curr_addr_d  = cfg_startaddr_i;
          bytes_left_d = cfg_size_i;
          datasize_d   = cfg_datasize_i;
          continuous_d = cfg_continuous_i;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (bus.data_valid_i) begin
          wdata_d = wdata_rep;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.l2_gnt_i) begin
          state_d = RUN;
          if (bytes_left_q <= L2_TRANS_SIZE'(step)) begin
            done_d = 1'b1;
            // A zero-size reload would leave an empty pass running, so it parks the channel instead.
            if (continuous_q && (cfg_size_i != '0)) begin
              curr_addr_d  = cfg_startaddr_i;
              bytes_left_d = cfg_size_i;
              continuous_d = cfg_continuous_i;
            end else begin
              curr_addr_d  = curr_addr_q + L2_AWIDTH_NOAL'(step);
              bytes_left_d = '0;
              state_d      = IDLE;
            end
          end else begin
            curr_addr_d  = curr_addr_q + L2_AWIDTH_NOAL'(step);
            bytes_left_d = bytes_left_q - L2_TRANS_SIZE'(step);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (cfg_clr_i) begin
      state_d      = IDLE;
      curr_addr_d  = '0;
      bytes_left_d = '0;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      curr_addr_q  <= '0;
      bytes_left_q <= '0;
      datasize_q   <= 2'b00;
      continuous_q <= 1'b0;
      wdata_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      curr_addr_q  <= curr_addr_d;
      bytes_left_q <= bytes_left_d;
      datasize_q   <= datasize_d;
      continuous_q <= continuous_d;
      wdata_q      <= wdata_d;
      done_q       <= done_d;
    end
  end

  assign cfg_en_o         = (state_q != IDLE);
  assign cfg_curr_addr_o  = curr_addr_q;
  assign cfg_bytes_left_o = bytes_left_q;
  assign evt_done_o       = done_q;

  assign bus.data_ready_o = (state_q == RUN);
  assign bus.l2_req_o     = (state_q == REQ);
  assign bus.l2_addr_o    = curr_addr_q;
  assign bus.l2_wdata_o   = wdata_q;
  assign bus.l2_be_o      = be;

endmodule

// File: tb/tb_afe_l2_chan_ctrl.sv
// Bench for afe_l2_chan_ctrl: directed scenarios with literal expectations, then randomized traffic
// against a transaction-level model of the channel (pass position, bytes left, pending sample).
module tb_afe_l2_chan_ctrl;
  localparam int AW = 12;
  localparam int TS = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [AW-1:0] cfg_startaddr_i = '0;
  logic [TS-1:0] cfg_size_i = '0;
  logic [1:0]    cfg_datasize_i = '0;
  logic          cfg_continuous_i = 1'b0;
  logic          cfg_en_i = 1'b0;
  logic          cfg_clr_i = 1'b0;
  logic          cfg_en_o;
  logic [AW-1:0] cfg_curr_addr_o;
  logic [TS-1:0] cfg_bytes_left_o;
  logic          evt_done_o;

  afe_l2_chan_ctrl_if #(.AW(AW)) bus ();

  afe_l2_chan_ctrl #(.L2_AWIDTH_NOAL(AW), .L2_TRANS_SIZE(TS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_startaddr_i(cfg_startaddr_i), .cfg_size_i(cfg_size_i),
    .cfg_datasize_i(cfg_datasize_i), .cfg_continuous_i(cfg_continuous_i),
    .cfg_en_i(cfg_en_i), .cfg_clr_i(cfg_clr_i),
    .cfg_en_o(cfg_en_o), .cfg_curr_addr_o(cfg_curr_addr_o),
    .cfg_bytes_left_o(cfg_bytes_left_o), .bus(bus.master), .evt_done_o(evt_done_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  bit            m_busy, m_hold, m_cont, m_done;
  logic [AW-1:0] m_addr;
  int            m_left;
  logic [1:0]    m_ds;
  logic [31:0]   m_wdata;

  typedef struct packed { logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } wr_t;
  wr_t wlog[$];
  int  done_cnt = 0;

  function automatic int step_of(input logic [1:0] ds);
    return (ds == 2'd0) ? 1 : (ds == 2'd1) ? 2 : 4;
  endfunction

  // Lanes covered by a write of s bytes at addr, aligned down to s within the word.
  function automatic logic [3:0] be_of(input logic [AW-1:0] addr, input int s);
    int lane;
    int mask;
    lane = int'(addr % 4);
    lane = lane - (lane % s);
    mask = ((1 << s) - 1) << lane;
    return mask[3:0];
  endfunction

  function automatic logic [31:0] wlog_addr(input int i);
    return (i < wlog.size()) ? wlog[i].addr : 32'hxxxxxxxx;
  endfunction
  function automatic logic [31:0] wlog_be(input int i);
    return (i < wlog.size()) ? {28'd0, wlog[i].be} : 32'hxxxxxxxx;
  endfunction
  function automatic logic [31:0] wlog_wdata(input int i);
    return (i < wlog.size()) ? wlog[i].wdata : 32'hxxxxxxxx;
  endfunction

  always @(negedge clk_i) begin
    int  s;
    bit  nd;
    if (!rst_ni) begin
      m_busy = 0; m_hold = 0; m_cont = 0; m_done = 0;
      m_addr = '0; m_left = 0; m_ds = '0; m_wdata = '0;
    end
    s = step_of(m_ds);
    chk("cfg_en_o", {31'd0, cfg_en_o}, {31'd0, m_busy});
    chk("cfg_curr_addr_o", {20'd0, cfg_curr_addr_o}, {20'd0, m_addr});
    chk("cfg_bytes_left_o", {16'd0, cfg_bytes_left_o}, m_left);
    chk("data_ready_o", {31'd0, bus.data_ready_o}, {31'd0, m_busy && !m_hold});
    chk("l2_req_o", {31'd0, bus.l2_req_o}, {31'd0, m_busy && m_hold});
    chk("l2_addr_o", {20'd0, bus.l2_addr_o}, {20'd0, m_addr});
    chk("l2_be_o", {28'd0, bus.l2_be_o}, (m_busy && m_hold) ? {28'd0, be_of(m_addr, s)} : 32'd0);
    chk("evt_done_o", {31'd0, evt_done_o}, {31'd0, m_done});
    if (m_busy && m_hold) chk("l2_wdata_o", bus.l2_wdata_o, m_wdata);

    if (rst_ni && bus.l2_req_o && bus.l2_gnt_i)
      wlog.push_back('{addr: {20'd0, bus.l2_addr_o}, be: bus.l2_be_o, wdata: bus.l2_wdata_o});
    if (evt_done_o) done_cnt++;

    if (rst_ni) begin
      nd = 0;
      if (cfg_clr_i) begin
        m_busy = 0; m_hold = 0; m_addr = '0; m_left = 0;
      end else if (!m_busy) begin
        if (cfg_en_i && cfg_size_i != 0) begin
          m_busy = 1; m_hold = 0; m_addr = cfg_startaddr_i; m_left = int'(cfg_size_i);
          m_ds = cfg_datasize_i; m_cont = cfg_continuous_i;
        end
      end else if (!m_hold) begin
        if (bus.data_valid_i) begin
          m_hold = 1;
          m_wdata = (s == 1) ? bus.data_i[7:0] * 32'h01010101 :
                    (s == 2) ? bus.data_i[15:0] * 32'h00010001 : bus.data_i;
        end
      end else if (bus.l2_gnt_i) begin
        m_hold = 0;
        if (m_left <= s) begin
          nd = 1;
          if (m_cont && cfg_size_i != 0) begin
            m_addr = cfg_startaddr_i; m_left = int'(cfg_size_i); m_cont = cfg_continuous_i;
          end else begin
            m_busy = 0; m_addr = m_addr + AW'(s); m_left = 0;
          end
        end else begin
          m_addr = m_addr + AW'(s); m_left = m_left - s;
        end
      end
      m_done = nd;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic start(input logic [AW-1:0] a, input logic [TS-1:0] sz,
                       input logic [1:0] ds, input logic cont);
    cfg_startaddr_i = a; cfg_size_i = sz; cfg_datasize_i = ds; cfg_continuous_i = cont;
    cfg_en_i = 1'b1;
    cyc(1);
    cfg_en_i = 1'b0;
  endtask

  task automatic clear();
    cfg_clr_i = 1'b1;
    cyc(1);
    cfg_clr_i = 1'b0;
  endtask

  // Offer one sample and return once it is accepted (the channel is then in its write phase).
  task automatic offer(input logic [31:0] d);
    bit ok = 0;
    bus.data_i = d;
    bus.data_valid_i = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk_i);
      ok = bus.data_ready_o;
    end
    if (!ok) timeout("offer_ready");
    @(posedge clk_i); #1;
    bus.data_valid_i = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    bit ok = 0;
    offer(d);
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk_i);
      ok = bus.l2_req_o && bus.l2_gnt_i;
    end
    if (!ok) timeout("send_grant");
    @(posedge clk_i); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bus.data_i = '0; bus.data_valid_i = 1'b0; bus.l2_gnt_i = 1'b0;

    // reset values
    #12;
    chk("rst_cfg_en", {31'd0, cfg_en_o}, 0);
    chk("rst_curr_addr", {20'd0, cfg_curr_addr_o}, 0);
    chk("rst_bytes_left", {16'd0, cfg_bytes_left_o}, 0);
    chk("rst_ready", {31'd0, bus.data_ready_o}, 0);
    chk("rst_req", {31'd0, bus.l2_req_o}, 0);
    chk("rst_addr", {20'd0, bus.l2_addr_o}, 0);
    chk("rst_wdata", bus.l2_wdata_o, 0);
    chk("rst_be", {28'd0, bus.l2_be_o}, 0);
    chk("rst_done", {31'd0, evt_done_o}, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    cyc(2);

    // word pass of two samples, grant always present
    bus.l2_gnt_i = 1'b1;
    wlog.delete(); d0 = done_cnt;
    start(12'h100, 16'd8, 2'b10, 1'b0);
    send(32'h11111111);
    send(32'h22222222);
    cyc(3);
    chk("A_nwrites", wlog.size(), 2);
    chk("A_addr0", wlog_addr(0), 32'h100);
    chk("A_addr1", wlog_addr(1), 32'h104);
    chk("A_be0", wlog_be(0), 32'hF);
    chk("A_be1", wlog_be(1), 32'hF);
    chk("A_done", done_cnt - d0, 1);
    chk("A_cfg_en", {31'd0, cfg_en_o}, 0);
    chk("A_bytes_left", {16'd0, cfg_bytes_left_o}, 0);

    // byte pass: lanes walk across the word
    wlog.delete(); d0 = done_cnt;
    start(12'h200, 16'd4, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) send(32'h000000A5);
    cyc(3);
    chk("B_nwrites", wlog.size(), 4);
    chk("B_be0", wlog_be(0), 32'h1);
    chk("B_be1", wlog_be(1), 32'h2);
    chk("B_be2", wlog_be(2), 32'h4);
    chk("B_be3", wlog_be(3), 32'h8);
    for (int i = 0; i < 4; i++) chk("B_wdata", wlog_wdata(i), 32'hA5A5A5A5);
    chk("B_curr_addr", {20'd0, cfg_curr_addr_o}, 32'h204);
    chk("B_done", done_cnt - d0, 1);

    // continuous single-word buffer
    wlog.delete(); d0 = done_cnt;
    start(12'h300, 16'd4, 2'b10, 1'b1);
    for (int i = 0; i < 3; i++) send(32'hC0DE0000 + i);
    cyc(2);
    chk("C_done", done_cnt - d0, 3);
    for (int i = 0; i < 3; i++) chk("C_addr", wlog_addr(i), 32'h300);
    chk("C_cfg_en", {31'd0, cfg_en_o}, 1);
    clear();
    cyc(1);
    chk("C_cleared", {31'd0, cfg_en_o}, 0);

    // grant stalled for five cycles: write held stable
    bus.l2_gnt_i = 1'b0;
    start(12'h010, 16'd8, 2'b01, 1'b0);
    offer(32'h1234ABCD);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("D_req", {31'd0, bus.l2_req_o}, 1);
      chk("D_addr", {20'd0, bus.l2_addr_o}, 32'h010);
      chk("D_be", {28'd0, bus.l2_be_o}, 32'h3);
      chk("D_wdata", bus.l2_wdata_o, 32'hABCDABCD);
      chk("D_ready", {31'd0, bus.data_ready_o}, 0);
    end
    @(posedge clk_i); #1;
    clear();

    // clear arriving together with grant in the write phase
    wlog.delete(); d0 = done_cnt;
    start(12'h040, 16'd8, 2'b10, 1'b0);
    offer(32'hDEADBEEF);
    cfg_clr_i = 1'b1; bus.l2_gnt_i = 1'b1;
    cyc(1);
    cfg_clr_i = 1'b0; bus.l2_gnt_i = 1'b0;
    @(negedge clk_i);
    chk("E_req", {31'd0, bus.l2_req_o}, 0);
    chk("E_cfg_en", {31'd0, cfg_en_o}, 0);
    chk("E_curr_addr", {20'd0, cfg_curr_addr_o}, 0);
    chk("E_bytes_left", {16'd0, cfg_bytes_left_o}, 0);
    chk("E_issued", wlog.size(), 1);
    cyc(3);
    chk("E_no_done", done_cnt - d0, 0);

    // ignored starts: zero size, start while running, start together with clear
    start(12'h080, 16'd0, 2'b10, 1'b0);
    cyc(1);
    chk("F_zero_size", {31'd0, cfg_en_o}, 0);
    start(12'h080, 16'd12, 2'b10, 1'b0);
    start(12'h500, 16'd4, 2'b00, 1'b1);
    cyc(1);
    chk("F_run_addr", {20'd0, cfg_curr_addr_o}, 32'h080);
    chk("F_run_left", {16'd0, cfg_bytes_left_o}, 12);
    bus.l2_gnt_i = 1'b1;
    send(32'h0);
    chk("F_step_addr", {20'd0, cfg_curr_addr_o}, 32'h084);
    chk("F_step_left", {16'd0, cfg_bytes_left_o}, 8);
    clear();
    cfg_size_i = 16'd8; cfg_en_i = 1'b1; cfg_clr_i = 1'b1;
    cyc(1);
    cfg_en_i = 1'b0; cfg_clr_i = 1'b0;
    cyc(1);
    chk("F_en_clr", {31'd0, cfg_en_o}, 0);

    // reset in the middle of a write
    bus.l2_gnt_i = 1'b0; d0 = done_cnt;
    start(12'h060, 16'd8, 2'b10, 1'b0);
    offer(32'h55AA55AA);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("G_req", {31'd0, bus.l2_req_o}, 0);
    chk("G_cfg_en", {31'd0, cfg_en_o}, 0);
    chk("G_wdata", bus.l2_wdata_o, 0);
    chk("G_be", {28'd0, bus.l2_be_o}, 0);
    cyc(2);
    rst_ni = 1'b1;
    cyc(3);
    chk("G_no_done", done_cnt - d0, 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.data_valid_i = ($urandom_range(9) < 6);
      bus.data_i       = $urandom;
      bus.l2_gnt_i     = $urandom_range(1);
      cfg_clr_i        = ($urandom_range(79) == 0);
      cfg_en_i         = ($urandom_range(7) == 0);
      cfg_startaddr_i  = ($urandom_range(3) == 0) ? (12'hFF0 | AW'($urandom_range(3) * 4))
                                                  : (AW'($urandom) & 12'hFFC);
      cfg_size_i       = TS'($urandom_range(16));
      cfg_datasize_i   = 2'($urandom_range(3));
      cfg_continuous_i = $urandom_range(1);
      cyc(1);
    end
    bus.data_valid_i = 1'b0; cfg_clr_i = 1'b0; cfg_en_i = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/afe_l2_chan_ctrl.md
AFE_L2_CHAN_CTRL -- requirements
Module: afe_l2_chan_ctrl

Interface
REQ-001 Parameter L2_AWIDTH_NOAL, default 12, byte-address width of the L2 channel buffer.
REQ-002 Parameter L2_TRANS_SIZE, default 16, width of the transfer-size and bytes-left counters.
REQ-003 clk_i  in  1  clock; all state changes on rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 cfg_startaddr_i  in  L2_AWIDTH_NOAL  buffer start byte address (word-aligned by the register block).
REQ-006 cfg_size_i  in  L2_TRANS_SIZE  buffer size in bytes.
REQ-007 cfg_datasize_i  in  2  sample size: 00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-008 cfg_continuous_i  in  1  reload start address and size at end of buffer.
REQ-009 cfg_en_i  in  1  single-cycle start pulse.
REQ-010 cfg_clr_i  in  1  single-cycle abort pulse.
REQ-011 cfg_en_o  out  1  channel busy, for status readback.
REQ-012 cfg_curr_addr_o  out  L2_AWIDTH_NOAL  next write byte address.
REQ-013 cfg_bytes_left_o  out  L2_TRANS_SIZE  bytes remaining in current buffer pass.
REQ-014 data_i  in  32  sample, right-aligned.
REQ-015 data_valid_i  in  1  sample valid.
REQ-016 data_ready_o  out  1  sample accepted when valid and ready are both high.
REQ-017 l2_req_o  out  1  L2 write request.
REQ-018 l2_gnt_i  in  1  L2 grant; a transfer completes in the cycle req and gnt are both high.
REQ-019 l2_addr_o  out  L2_AWIDTH_NOAL  write byte address.
REQ-020 l2_wdata_o  out  32  write data, sample replicated into every lane of its size.
REQ-021 l2_be_o  out  4  byte enables.
REQ-022 evt_done_o  out  1  single-cycle pulse at end of each buffer pass.

Function
REQ-023 FSM states IDLE, RUN, REQ; cfg_en_o SHALL be 1 in every state except IDLE.
REQ-024 IDLE: cfg_en_i with cfg_size_i!=0 -> load curr_addr=cfg_startaddr_i, bytes_left=cfg_size_i, latch datasize, go RUN; cfg_en_i with cfg_size_i==0 ignored.
REQ-025 cfg_en_i outside IDLE SHALL be ignored.
REQ-026 data_ready_o SHALL be 1 only in RUN; an accepted sample is registered and the FSM enters REQ in the next cycle.
REQ-027 REQ: l2_req_o=1, and l2_addr_o, l2_wdata_o, l2_be_o SHALL be held stable until grant.
REQ-028 step = 1/2/4 bytes for byte/half/word; l2_be_o = 0001<<addr[1:0] (byte), 0011<<{addr[1],0} (half), 1111 (word).
REQ-029 On grant: curr_addr += step (modulo 2^L2_AWIDTH_NOAL), bytes_left -= step; if bytes_left <= step before update, bytes_left becomes 0 and the pass ends.
REQ-030 Pass end: evt_done_o=1 for exactly the cycle after the grant; continuous=1 -> reload start address and size, go RUN; else go IDLE.
REQ-031 Non-final grant -> RUN; zero-bubble throughput is not required (max one sample per two cycles).
REQ-032 cfg_clr_i has priority over all events in every state: next state IDLE, l2_req_o low next cycle, curr_addr and bytes_left cleared to 0, no evt_done_o, pending sample discarded.
REQ-033 cfg_clr_i and cfg_en_i in the same cycle: clear wins; channel stays IDLE.
REQ-034 Grant and clear in the same cycle: the write counts as issued on the bus, but the counters are still cleared and no done pulse is generated.
REQ-035 cfg_startaddr_i, cfg_size_i, and cfg_continuous_i are sampled only at start and at continuous reload.

Reset
REQ-036 On reset, state IDLE and all outputs 0: cfg_en_o, cfg_curr_addr_o, cfg_bytes_left_o, data_ready_o, l2_req_o, l2_addr_o, l2_wdata_o, l2_be_o, evt_done_o.
REQ-037 Reset mid-transfer SHALL abort immediately, with no done pulse.

Verification
REQ-038 Setup: start=0x100, size=8, word, non-continuous, en pulse, 2 samples, gnt tied 1. Required: writes to 0x100 and 0x104 with be=1111, then evt_done_o once, then cfg_en_o=0 and bytes_left=0.
REQ-039 Byte mode: start=0x200, size=4, data 0xA5. Required: be sequence 0001, 0010, 0100, 1000; wdata 0xA5A5A5A5; curr_addr ends at 0x204.
REQ-040 Continuous: size=4, word, 3 samples. Required: evt_done_o after each sample, every address equal to the start address, cfg_en_o remaining 1.
REQ-041 Grant stalled 5 cycles. Required: req, addr, data, and be stable throughout; data_ready_o=0.
REQ-042 cfg_clr_i asserted during REQ. Required: req low the next cycle, IDLE, counters 0, no done pulse.
REQ-043 en with size=0, and en during RUN. Required: both ignored; the state and the counters do not change.
